// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift-chain sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, chain select encodings, counter width helper.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Chain select: parallel load vs. serial shift/hold.
  localparam logic SEL_PAR = 1'b1;
  localparam logic SEL_SER = 1'b0;

  // Width of a counter that spans 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sp_chain.sv
// WIDTH-bit serial/parallel chain: each stage loads, shifts left, or holds.
// Latency: one clock from sel/shift_en to q.
// Backpressure: none; the chain follows its controls every cycle.
//
// Ports: clk, rst (async active-low), sel (1 = parallel load), shift_en,
//        pdin (parallel word), sin (serial in to LSB), q (chain), sout (MSB).
module sp_chain
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             shift_en,
  input  logic             sin,
  input  logic [WIDTH-1:0] pdin,
  output logic [WIDTH-1:0] q,
  output logic             sout
);

  logic [WIDTH-1:0] chain_q;
  logic [WIDTH-1:0] chain_d;
  logic [WIDTH-1:0] shifted;

  assign shifted = {chain_q[WIDTH-2:0], sin};

  // Per-stage three-way choice; parallel load takes priority over shift.
  always_comb begin
    chain_d = chain_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel == SEL_PAR) begin
        chain_d[i] = pdin[i];
      end else if (shift_en) begin
        chain_d[i] = shifted[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q    = chain_q;
  assign sout = chain_q[WIDTH-1];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer: loads a word into the chain, shifts it out MSB-first while capturing sin.
// Latency: done visible WIDTH*DIV+2 edges after the accepting edge.
// Backpressure: ready high only in IDLE; start outside IDLE is dropped, not queued.
//
// Ports: clk, rst (async active-low), start/din (request + word), ready,
//        sel (chain select), sout/sin (serial pair), dout (captured word), done (pulse).
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             sel,
  output logic             sout,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             done
);

  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam int DIV_W = cnt_width(DIV);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  logic             shift_en;
  logic             div_last;
  logic             bit_last;
  logic [WIDTH-1:0] chain_q;

  assign div_last = (div_q == DIV_W'(DIV - 1));
  assign bit_last = (bit_cnt_q == BIT_W'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    dout_d    = dout_q;
    shift_en  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          hold_d  = din;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        bit_cnt_d = '0;
        div_d     = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (div_last) begin
          shift_en  = 1'b1;
          div_d     = '0;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_last) begin
            state_d = ST_DONE;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_DONE: begin
        // The chain holds in DONE, so its value is the captured word.
        dout_d  = chain_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      dout_q    <= dout_d;
    end
  end

  sp_chain #(
    .WIDTH (WIDTH)
  ) u_chain (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .shift_en (shift_en),
    .sin      (sin),
    .pdin     (hold_q),
    .q        (chain_q),
    .sout     (sout)
  );

  // Status decoded purely from registered state.
  assign ready = (state_q == ST_IDLE);
  assign sel   = (state_q == ST_LOAD) ? SEL_PAR : SEL_SER;
  assign done  = (state_q == ST_DONE);

  // In DONE the word is shown straight from the chain; the register keeps it afterwards.
  assign dout  = (state_q == ST_DONE) ? chain_q : dout_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with WIDTH=8 at DIV=1 and DIV=4.
// Latency: checks done timing against WIDTH*DIV+2 edges.
// Backpressure: exercises ignored starts and back-to-back requests.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] din;
  logic       use4;
  logic       lb;
  logic       sin_drv;

  logic       start1, start4, sin1, sin4;
  logic       rdy1, rdy4, sel1, sel4, sout1, sout4, done1, done4;
  logic [7:0] dout1, dout4;
  logic       ready_m, sel_m, sout_m, done_m;
  logic [7:0] dout_m;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign start1  = start & ~use4;
  assign start4  = start & use4;
  assign sin1    = lb ? sout1 : sin_drv;
  assign sin4    = lb ? sout4 : sin_drv;
  assign ready_m = use4 ? rdy4  : rdy1;
  assign sel_m   = use4 ? sel4  : sel1;
  assign sout_m  = use4 ? sout4 : sout1;
  assign done_m  = use4 ? done4 : done1;
  assign dout_m  = use4 ? dout4 : dout1;

  shift_seq_ctrl #(.WIDTH(8), .DIV(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start1), .din(din), .ready(rdy1), .sel(sel1),
    .sout(sout1), .sin(sin1), .dout(dout1), .done(done1)
  );

  shift_seq_ctrl #(.WIDTH(8), .DIV(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start4), .din(din), .ready(rdy4), .sel(sel4),
    .sout(sout4), .sin(sin4), .dout(dout4), .done(done4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transfer on the selected instance. done_edge counts edges from the
  // accepting edge to the first edge that sees done high (-1 on timeout).
  task automatic xfer(input string tag, input logic [7:0] d, input int pulse_at,
                      input logic [7:0] pulse_d, output int done_edge,
                      output logic [31:0] trace, output logic [7:0] dout_seen);
    int wd;
    wd = use4 ? 32 : 8;
    chk({tag, "_ready_idle"}, 32'(ready_m), 32'd1);
    start = 1'b1;
    din   = d;
    step();
    chk({tag, "_sel_load"}, 32'(sel_m), 32'd1);
    chk({tag, "_ready_load"}, 32'(ready_m), 32'd0);
    start     = 1'b0;
    din       = 8'h00;
    done_edge = -1;
    trace     = '0;
    dout_seen = '0;
    for (int n = 1; n <= wd + 20; n++) begin
      if (n == pulse_at) begin
        start = 1'b1;
        din   = pulse_d;
      end else begin
        start = 1'b0;
      end
      step();
      if (n <= wd) trace = {trace[30:0], sout_m};
      if (done_m) begin
        done_edge = n + 1;
        dout_seen = dout_m;
        break;
      end
    end
    start = 1'b0;
    step();
    chk({tag, "_done_1cyc"}, 32'(done_m), 32'd0);
    chk({tag, "_ready_after"}, 32'(ready_m), 32'd1);
  endtask

  int          de;
  logic [31:0] tr;
  logic [7:0]  dv;
  int          cnt;
  int          nd;
  int          d_edge [2];
  logic [7:0]  d_val  [2];

  initial begin
    rst = 1'b0; start = 1'b0; din = 8'h00; use4 = 1'b0; lb = 1'b1; sin_drv = 1'b0;
    repeat (2) step();

    // Reset state on both instances
    chk("rst_ready1", 32'(rdy1), 32'd1);
    chk("rst_sel1",   32'(sel1), 32'd0);
    chk("rst_done1",  32'(done1), 32'd0);
    chk("rst_sout1",  32'(sout1), 32'd0);
    chk("rst_dout1",  32'(dout1), 32'd0);
    chk("rst_ready4", 32'(rdy4), 32'd1);
    chk("rst_sel4",   32'(sel4), 32'd0);
    chk("rst_done4",  32'(done4), 32'd0);
    chk("rst_sout4",  32'(sout4), 32'd0);
    chk("rst_dout4",  32'(dout4), 32'd0);
    rst = 1'b1;
    step();

    // Loopback, DIV=1
    use4 = 1'b0; lb = 1'b1;
    xfer("lb", 8'hA5, 0, 8'h00, de, tr, dv);
    chk("lb_dout", 32'(dv), 32'h0000_00A5);
    chk("lb_done_edge", 32'(de), 32'd10);
    chk("lb_sout_seq", tr, 32'h0000_00A5);

    // Serial output, DIV=4, sin=0
    use4 = 1'b1; lb = 1'b0; sin_drv = 1'b0;
    xfer("ser", 8'hA5, 0, 8'h00, de, tr, dv);
    chk("ser_dout", 32'(dv), 32'h0);
    chk("ser_done_edge", 32'(de), 32'd34);
    chk("ser_sout_seq", tr, 32'hF0F0_0F0F);

    // Capture, DIV=1, sin=1
    use4 = 1'b0; lb = 1'b0; sin_drv = 1'b1;
    xfer("cap", 8'h00, 0, 8'h00, de, tr, dv);
    chk("cap_dout", 32'(dv), 32'h0000_00FF);
    chk("cap_done_edge", 32'(de), 32'd10);

    // Busy start during SHIFT is ignored, DIV=4 loopback
    use4 = 1'b1; lb = 1'b1; sin_drv = 1'b0;
    xfer("busy", 8'hA5, 10, 8'h3C, de, tr, dv);
    chk("busy_dout", 32'(dv), 32'h0000_00A5);
    chk("busy_done_edge", 32'(de), 32'd34);
    cnt = 0;
    repeat (50) begin
      step();
      if (done_m) cnt++;
    end
    chk("busy_no_extra_done", 32'(cnt), 32'd0);
    chk("busy_dout_held", 32'(dout_m), 32'h0000_00A5);

    // Mid-transfer reset after the 3rd shift (edges k+5, k+9, k+13)
    start = 1'b1; din = 8'hF0;
    step();
    start = 1'b0;
    repeat (13) step();
    chk("mrst_pre_sout", 32'(sout_m), 32'd1);
    rst = 1'b0;
    #1;
    chk("mrst_ready", 32'(ready_m), 32'd1);
    chk("mrst_sel",   32'(sel_m), 32'd0);
    chk("mrst_done",  32'(done_m), 32'd0);
    chk("mrst_sout",  32'(sout_m), 32'd0);
    chk("mrst_dout",  32'(dout_m), 32'd0);
    cnt = 0;
    repeat (3) begin
      step();
      if (done_m) cnt++;
    end
    rst = 1'b1;
    repeat (40) begin
      step();
      if (done_m) cnt++;
    end
    chk("mrst_no_done", 32'(cnt), 32'd0);
    xfer("mrst_fresh", 8'h5A, 0, 8'h00, de, tr, dv);
    chk("mrst_fresh_dout", 32'(dv), 32'h0000_005A);
    chk("mrst_fresh_edge", 32'(de), 32'd34);

    // Back-to-back with start held, DIV=1 loopback
    use4 = 1'b0; lb = 1'b1;
    nd = 0;
    d_edge[0] = 0; d_edge[1] = 0; d_val[0] = 8'h00; d_val[1] = 8'h00;
    start = 1'b1; din = 8'h11;
    step();
    din = 8'h22;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (n == 10) chk("b2b_ready_gap", 32'(ready_m), 32'd1);
      if (n == 11) begin
        chk("b2b_ready_load2", 32'(ready_m), 32'd0);
        start = 1'b0;
      end
      if (done_m) begin
        if (nd < 2) begin
          d_edge[nd] = n;
          d_val[nd]  = dout_m;
        end
        nd++;
      end
    end
    chk("b2b_done_count", 32'(nd), 32'd2);
    chk("b2b_dout1", 32'(d_val[0]), 32'h0000_0011);
    chk("b2b_dout2", 32'(d_val[1]), 32'h0000_0022);
    chk("b2b_spacing", 32'(d_edge[1] - d_edge[0]), 32'd11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencer for a WIDTH-bit serial/parallel shift chain built from dcell-style stages. Accepts a parallel word over a start/ready handshake and loads it into the chain. Shifts the word out MSB-first on `sout` at one bit per DIV clocks while capturing `sin` into the vacated LSB. Presents the captured word with a one-cycle `done` pulse. It is the control layer that sequences the chain's parallel-load/serial-shift select, and it adds a hold mode so the chain keeps its value between transfers.

## Interface
Parameters:
- WIDTH, 8, chain length in bits; legal range 2..32
- DIV, 4, clocks per bit period; legal range 1..255

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset; low forces reset state immediately
- start  in  1  transfer request; accepted only when `ready`=1
- din  in  WIDTH  parallel load word, sampled on the accepting edge
- ready  out  1  high only in IDLE
- sel  out  1  chain select: 1 = parallel load (LOAD state), 0 otherwise
- sout  out  1  serial out = chain[WIDTH-1]
- sin  in  1  serial in, sampled at the end of each bit period
- dout  out  WIDTH  captured word, updated on entry to DONE and then held
- done  out  1  one-cycle pulse in DONE state

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- **IDLE**
  - `ready`=1 and the chain holds its value.
  - `start`=1 registers `din` into a holding register and moves to LOAD.
- **LOAD**
  - `sel`=1 for exactly one cycle; the chain loads the holding register.
  - Bit counter and divider counter clear to 0; next state is SHIFT.
- **SHIFT**
  - The divider counts 0..DIV-1.
  - When divider = DIV-1: the chain shifts left, {chain[WIDTH-2:0], sin}; the bit counter increments and the divider wraps to 0.
  - On all other cycles the chain holds.
  - After the WIDTH-th shift, next state is DONE.
- **DONE**
  - `dout` takes the chain value and `done`=1 for one cycle.
  - Next state is IDLE.
- `start` is ignored in LOAD, SHIFT and DONE; no queueing.
- `start` held high continuously produces back-to-back transfers, with `ready` high for one cycle between them.
- Counter widths: bit counter uses $clog2(WIDTH+1) bits; divider uses $clog2(DIV) bits, minimum 1.
- DIV=1: a shift occurs every SHIFT cycle.

## Timing
- Reset values: state IDLE, chain 0, `dout` 0, `sout` 0, `ready` 1, `sel` 0, `done` 0, counters 0.
- Start accepted at edge k:
  - LOAD occupies cycle k..k+1.
  - SHIFT occupies WIDTH*DIV cycles.
  - `done` is high in the cycle following edge k+1+WIDTH*DIV.
  - `ready` returns high one cycle after `done`.
- Start-to-done latency: WIDTH*DIV+2 edges.
- `sout` shows bit WIDTH-1-i of `din` for the DIV cycles of bit period i (i = 0..WIDTH-1).
- `sin` is sampled at the last cycle of each bit period. The first sample becomes the MSB-side-most captured bit, i.e. `dout[WIDTH-1]`.
- Reset asserted mid-transfer: abort immediately with no `done` pulse and `dout` cleared. After reset release, the first edge is in IDLE.
- Outputs `ready`, `sel` and `done` are decoded from registered state only, with no combinational path from inputs.

## Structure
- Package `shift_seq_pkg`:
  - state enum (IDLE, LOAD, SHIFT, DONE)
  - select encodings SEL_PAR=1, SEL_SER=0
- Sub-module `sp_chain`: WIDTH-bit chain of stages.
  - Per-stage 3-way choice: parallel load, serial shift, hold.
  - Shared `sel`/`shift_en` inputs, `clk`/`rst`, exported `sout` and parallel `q`.
- `shift_seq_ctrl` contains the FSM, divider, bit counter, holding register and `dout` register.

## Test plan
- **Loopback:** WIDTH=8, DIV=1, `sin` tied to `sout`, `din`=0xA5. Require `dout`=0xA5 and `done` exactly 10 edges after the accepting edge.
- **Serial output:** WIDTH=8, DIV=4, `din`=0xA5, `sin`=0. `sout` must read 1,0,1,0,0,1,0,1, each held 4 cycles. Require `dout`=0x00 and `done` at edge 34.
- **Capture:** `din`=0x00, `sin`=1 throughout. Require `dout`=0xFF.
- **Busy start:** pulse `start` with `din`=0x3C during SHIFT of a 0xA5 transfer. The transfer completes unchanged, and there is no second `done` without a new start in IDLE.
- **Mid-transfer reset:** drive `rst` low after the 3rd shift. All outputs take reset values immediately, no `done` pulse occurs, and a fresh transfer with 0x5A loops back correctly.
- **Back-to-back:** hold `start`=1 with `din` changing 0x11 then 0x22. Require `done` pulses WIDTH*DIV+3 edges apart and `dout` equal to 0x11 then 0x22 (loopback).
